// File: rtl/cim_bitplane_packer.sv
// Frame buffer that turns pixel beats into MSB-first bit-plane words for the CIM input FIFO.
// Collects NUM_INPUTS pixels, then emits PIXEL_BITS words with bit i = bit p of pixel i.
module cim_bitplane_packer #(
  parameter int unsigned NUM_INPUTS = 64,
  parameter int unsigned PIXEL_BITS = 8,
  parameter int unsigned BEAT_PIX   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           soft_reset_pulse,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [BEAT_PIX*PIXEL_BITS-1:0] pix_data,
  input  logic                           fifo_full,
  output logic                           fifo_push,
  output logic [NUM_INPUTS-1:0]          fifo_wdata,
  output logic                           busy,
  output logic                           frame_done_pulse,
  output logic [7:0]                     frame_count
);

  localparam int unsigned NumBeats = NUM_INPUTS / BEAT_PIX;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned PlaneW   = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;

  localparam logic [BeatW-1:0]  LastBeat = BeatW'(NumBeats - 1);
  localparam logic [PlaneW-1:0] TopPlane = PlaneW'(PIXEL_BITS - 1);

  logic [0:0]                             state_q, state_d;
  logic [BeatW-1:0]                       beat_cnt_q, beat_cnt_d;
  logic [PlaneW-1:0]                      plane_q, plane_d;
  logic [NUM_INPUTS-1:0][PIXEL_BITS-1:0]  pix_buf_q, pix_buf_d;
  logic                                   frame_done_q, frame_done_d;
  logic [7:0]                             frame_count_q, frame_count_d;

  // Outputs are pure functions of state so the FIFO sees a stable word while it is full.
  always_comb begin
    pix_ready  = (state_q == ST_COLLECT);
    fifo_push  = (state_q == ST_EMIT) && !fifo_full;
    busy       = (state_q == ST_EMIT) || (beat_cnt_q != '0);
    fifo_wdata = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      fifo_wdata[i] = (state_q == ST_EMIT) && pix_buf_q[i][plane_q];
    end
  end

  assign frame_done_pulse = frame_done_q;
  assign frame_count      = frame_count_q;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    plane_d       = plane_q;
    pix_buf_d     = pix_buf_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    if (state_q == ST_COLLECT) begin
      if (pix_valid) begin
        for (int unsigned b = 0; b < NumBeats; b++) begin
          if (beat_cnt_q == BeatW'(b)) begin
            for (int unsigned k = 0; k < BEAT_PIX; k++) begin
              pix_buf_d[b*BEAT_PIX + k] = pix_data[k*PIXEL_BITS +: PIXEL_BITS];
            end
          end
        end
        if (beat_cnt_q == LastBeat) begin
          beat_cnt_d = '0;
          plane_d    = TopPlane;
          state_d    = ST_EMIT;
        end else begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
        end
      end
    end else if (fifo_push) begin
      if (plane_q == '0) begin
        state_d       = ST_COLLECT;
        plane_d       = TopPlane;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        plane_d = plane_q - PlaneW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || soft_reset_pulse) begin
      state_q      <= ST_COLLECT;
      beat_cnt_q   <= '0;
      plane_q      <= TopPlane;
      pix_buf_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      plane_q      <= plane_d;
      pix_buf_q    <= pix_buf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Soft reset clears the datapath but keeps the completed-frame tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
    end else if (!soft_reset_pulse) begin
      frame_count_q <= frame_count_d;
    end
  end

`ifndef SYNTHESIS
  initial begin
    if (NUM_INPUTS % BEAT_PIX != 0) begin
      $fatal(1, "NUM_INPUTS must be a multiple of BEAT_PIX");
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full)) else $error("push while fifo_full");
      assert (int'(plane_q) < int'(PIXEL_BITS)) else $error("plane out of range");
    end
  end
`endif

endmodule

// File: tb/tb_cim_bitplane_packer.sv
// Self-checking bench for cim_bitplane_packer: vector table plus reset, backpressure
// and wrap sequences, with a scoreboard of expected bit-plane words.
module tb_cim_bitplane_packer;

  localparam int unsigned NI = 64;
  localparam int unsigned PB = 8;
  localparam int unsigned BP = 4;
  localparam int unsigned NB = NI / BP;

  logic              clk = 1'b0;
  logic              rst;
  logic              soft_reset_pulse;
  logic              pix_valid;
  logic              pix_ready;
  logic [BP*PB-1:0]  pix_data;
  logic              fifo_full;
  logic              fifo_push;
  logic [NI-1:0]     fifo_wdata;
  logic              busy;
  logic              frame_done_pulse;
  logic [7:0]        frame_count;

  always #5 clk = ~clk;

  cim_bitplane_packer #(
    .NUM_INPUTS(NI),
    .PIXEL_BITS(PB),
    .BEAT_PIX  (BP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .soft_reset_pulse(soft_reset_pulse),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .fifo_full       (fifo_full),
    .fifo_push       (fifo_push),
    .fifo_wdata      (fifo_wdata),
    .busy            (busy),
    .frame_done_pulse(frame_done_pulse),
    .frame_count     (frame_count)
  );

  typedef struct {
    logic [NI-1:0] w;
    int            plane;
  } exp_t;

  typedef struct {
    string         name;
    bit            ramp;
    logic [31:0]   b0;
    logic [31:0]   rest;
    int            full_at;
    logic [63:0]   e7;
    logic [63:0]   e5;
    logic [63:0]   e0;
  } vec_t;

  exp_t          exp_q[$];
  int            push_cyc[$];
  logic [NI-1:0] got [PB];
  logic [7:0]    px [NI];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            frame_pushes = 0;
  int            present_cyc = 0;
  int            last_done_cyc = -1;
  bit            check_period = 1'b0;
  bit            prev_final = 1'b0;
  logic [7:0]    mon_fc = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic logic [NI-1:0] plane_word(int p);
    logic [NI-1:0] w;
    for (int i = 0; i < NI; i++) w[i] = px[i][p];
    return w;
  endfunction

  // Scoreboard: pop and compare on every push, and track frame_done / frame_count.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (fifo_full) check("no_push_while_full", 64'(fifo_push), 64'd0);
      if (frame_done_pulse || prev_final) begin
        check("done_after_last_push", 64'(frame_done_pulse), 64'(prev_final));
        if (frame_done_pulse) begin
          check("ready_with_done", 64'(pix_ready), 64'd1);
          check("frame_count_at_done", 64'(frame_count), 64'(mon_fc));
          if (check_period && last_done_cyc >= 0)
            check("frame_period", 64'(cyc - last_done_cyc), 64'd24);
          last_done_cyc = cyc;
        end
      end
      prev_final = 1'b0;
      if (fifo_push) begin
        if (exp_q.size() == 0) begin
          check("unexpected_push", 64'(fifo_push), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("plane%0d_word", e.plane), 64'(fifo_wdata), 64'(e.w));
          got[e.plane] = fifo_wdata;
          frame_pushes++;
          push_cyc.push_back(cyc);
          if (e.plane == 0) begin
            prev_final = 1'b1;
            mon_fc     = mon_fc + 8'd1;
          end
        end
      end
    end else begin
      prev_final = 1'b0;
      mon_fc     = 8'd0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!pix_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pix_ready) check("ready_timeout", 64'(pix_ready), 64'd1);
  endtask

  // Drives nbeats beats from px; pix_valid is left high for the caller to drop.
  task automatic drive_frame(int nbeats, bit expect_out);
    logic [BP*PB-1:0] d;
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < BP; k++) d[k*PB +: PB] = px[b*BP + k];
      pix_data  = d;
      pix_valid = 1'b1;
      wait_ready();
      if (expect_out && b == nbeats - 1) begin
        for (int p = PB - 1; p >= 0; p--) begin
          e.w     = plane_word(p);
          e.plane = p;
          exp_q.push_back(e);
        end
        present_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_pushes = 0;
    push_cyc.delete();
    for (int p = 0; p < PB; p++) got[p] = 'x;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[4];
    logic [31:0]   word;
    logic [7:0]    exp_fc;
    logic [NI-1:0] held;
    int            n;

    vecs[0] = '{"ramp", 1'b1, 32'h0, 32'h0, -1,
                64'h0, 64'hFFFFFFFF_00000000, 64'hAAAAAAAA_AAAAAAAA};
    vecs[1] = '{"lane_order", 1'b0, 32'h80000001, 32'h0, -1, 64'h8, 64'h0, 64'h1};
    vecs[2] = '{"backpressure", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,
                {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};
    vecs[3] = '{"a5_pattern", 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, -1,
                {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};

    rst = 1'b1; soft_reset_pulse = 1'b0; pix_valid = 1'b0; pix_data = '0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_pix_ready", 64'(pix_ready), 64'd1);
    check("reset_fifo_push", 64'(fifo_push), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wdata", 64'(fifo_wdata), 64'd0);
    check("reset_done", 64'(frame_done_pulse), 64'd0);
    check("reset_frame_count", 64'(frame_count), 64'd0);

    exp_fc = 8'd0;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NI; i++) begin
        word  = (i / BP == 0) ? vecs[v].b0 : vecs[v].rest;
        px[i] = vecs[v].ramp ? 8'(i) : word[(i % BP)*PB +: PB];
      end
      start_frame();
      drive_frame(NB, 1'b1);
      pix_valid = 1'b0;
      if (vecs[v].full_at >= 0) begin
        n = 0;
        while (frame_pushes < vecs[v].full_at && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        held = plane_word(PB - 1 - vecs[v].full_at);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          #1;
          check("full_no_push", 64'(fifo_push), 64'd0);
          check("full_pix_ready", 64'(pix_ready), 64'd0);
          check("full_word_held", 64'(fifo_wdata), 64'(held));
          @(posedge clk);
          #1;
        end
        fifo_full = 1'b0;
      end
      drain();
      exp_fc = exp_fc + 8'd1;
      check({vecs[v].name, "_push_count"}, 64'(frame_pushes), 64'd8);
      check({vecs[v].name, "_plane7"}, 64'(got[7]), vecs[v].e7);
      check({vecs[v].name, "_plane5"}, 64'(got[5]), vecs[v].e5);
      check({vecs[v].name, "_plane0"}, 64'(got[0]), vecs[v].e0);
      check({vecs[v].name, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
      check({vecs[v].name, "_idle_wdata"}, 64'(fifo_wdata), 64'd0);
      check({vecs[v].name, "_idle_busy"}, 64'(busy), 64'd0);
      if (vecs[v].full_at < 0 && push_cyc.size() == 8) begin
        check({vecs[v].name, "_first_push_latency"}, 64'(push_cyc[0]), 64'(present_cyc + 1));
        for (int k = 1; k < 8; k++)
          check({vecs[v].name, "_consecutive_push"}, 64'(push_cyc[k]), 64'(push_cyc[0] + k));
      end
    end

    // Soft reset discards a partial frame and keeps frame_count.
    for (int i = 0; i < NI; i++) px[i] = 8'hFF;
    start_frame();
    drive_frame(5, 1'b0);
    pix_valid = 1'b0;
    check("soft_busy_before", 64'(busy), 64'd1);
    soft_reset_pulse = 1'b1;
    @(posedge clk);
    #1 soft_reset_pulse = 1'b0;
    check("soft_busy_after", 64'(busy), 64'd0);
    check("soft_frame_count_kept", 64'(frame_count), 64'(exp_fc));
    check("soft_pix_ready", 64'(pix_ready), 64'd1);
    for (int i = 0; i < NI; i++) px[i] = 8'h00;
    drive_frame(NB, 1'b1);
    pix_valid = 1'b0;
    drain();
    exp_fc = exp_fc + 8'd1;
    check("soft_push_count", 64'(frame_pushes), 64'd8);
    check("soft_frame_count_next", 64'(frame_count), 64'(exp_fc));

    // Synchronous reset after the third push aborts the emit.
    for (int i = 0; i < NI; i++) px[i] = 8'hFF;
    start_frame();
    drive_frame(NB, 1'b1);
    pix_valid = 1'b0;
    n = 0;
    while (frame_pushes < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_three_pushes_seen", 64'(frame_pushes), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    mon_fc = 8'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pix_ready", 64'(pix_ready), 64'd1);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_no_push", 64'(fifo_push), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_further_push", 64'(frame_pushes), 64'd3);
    for (int i = 0; i < NI; i++) px[i] = 8'($urandom);
    start_frame();
    drive_frame(NB, 1'b1);
    pix_valid = 1'b0;
    drain();
    check("rst_fresh_push_count", 64'(frame_pushes), 64'd8);
    check("rst_fresh_frame_count", 64'(frame_count), 64'd1);

    // 256 back-to-back frames with pix_valid held high.
    rst = 1'b1;
    mon_fc = 8'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_period  = 1'b1;
    last_done_cyc = -1;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < NI; i++) px[i] = 8'(i * 3 + f);
      drive_frame(NB, 1'b1);
    end
    pix_valid = 1'b0;
    drain();
    check_period = 1'b0;
    check("wrap_frame_count", 64'(frame_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
